// File: rtl/inner_dot_t9_requant.sv
// Window sequencer for an external 3x3 MAC, followed by bias/round/ReLU/saturate
// requantization and a first-word-fall-through result FIFO with registered outputs.
module inner_dot_t9_requant #(
  parameter int SUM_WIDTH  = 20,
  parameter int TAPS       = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tap_valid,
  output logic                        tap_ready,
  output logic                        accum_clr,
  input  logic signed [SUM_WIDTH-1:0] sum,
  input  logic signed [15:0]          bias,
  input  logic        [3:0]           shift,
  input  logic                        relu_en,
  output logic signed [7:0]           q_data,
  output logic                        q_valid,
  input  logic                        q_ready
);

  localparam int CW  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int OW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int S1W = SUM_WIDTH + 1;
  localparam int S2W = SUM_WIDTH + 2;

  localparam logic signed [S2W-1:0] MAX_Q = S2W'(127);
  localparam logic signed [S2W-1:0] MIN_Q = -S2W'(128);

  // Both handshakes transfer on a rising edge only when valid && ready are high
  // together; valid never waits on ready, and ready may depend on valid-free state.
  logic [CW-1:0] cnt;
  logic [OW-1:0] outst;
  logic          tap_take;
  logic          win_start;
  logic          last_tap;
  logic          pop;
  logic          push;

  assign tap_ready = (cnt != '0) || (outst < OW'(FIFO_DEPTH));
  assign tap_take  = tap_valid && tap_ready;
  assign win_start = tap_take && (cnt == '0);
  assign last_tap  = (cnt == CW'(TAPS - 1));
  assign accum_clr = win_start;
  assign pop       = q_valid && q_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tap_take) begin
      cnt <= last_tap ? '0 : cnt + 1'b1;
    end
  end

  // Windows in flight or buffered; caps the FIFO so a push can never find it full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else begin
      case ({win_start, pop})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

  // Stage 1: the sum is final the cycle after the last tap; capture it with bias.
  logic                  done_d;
  logic signed [S1W-1:0] s1;
  logic                  s1_v;
  logic        [3:0]     shift_q;
  logic                  relu_q;
  logic signed [S1W-1:0] sum_ext;
  logic signed [S1W-1:0] bias_ext;

  assign sum_ext  = {sum[SUM_WIDTH-1], sum};
  assign bias_ext = {{(S1W-16){bias[15]}}, bias};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_d  <= 1'b0;
      s1      <= '0;
      s1_v    <= 1'b0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      done_d <= tap_take && last_tap;
      s1_v   <= done_d;
      if (done_d) begin
        s1      <= sum_ext + bias_ext;
        shift_q <= shift;
        relu_q  <= relu_en;
      end
    end
  end

  // Stage 2: round-half-up arithmetic shift, optional ReLU, saturate to int8.
  logic signed [S2W-1:0] s1_wide;
  logic signed [S2W-1:0] rnd;
  logic signed [S2W-1:0] rsum;
  logic signed [S2W-1:0] r;
  logic signed [7:0]     q_res;

  always_comb begin
    s1_wide = {s1[S1W-1], s1};
    rnd     = '0;
    if (shift_q != 4'd0) rnd = S2W'(1) << (shift_q - 4'd1);
    rsum = s1_wide + rnd;
    r    = rsum >>> shift_q;
    if (relu_q && (r < 0)) r = '0;
    if (r > MAX_Q)      q_res = 8'sd127;
    else if (r < MIN_Q) q_res = -8'sd128;
    else                q_res = r[7:0];
  end

  assign push = s1_v;

  // FIFO: q_data/q_valid are registers that always mirror the next head entry.
  logic signed [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_ptr_n;
  logic [OW-1:0]     fifo_cnt;
  logic [OW-1:0]     cnt_after_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    cnt_after_pop = fifo_cnt - OW'(pop);
    rd_ptr_n      = pop ? ptr_inc(rd_ptr) : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      q_valid  <= 1'b0;
      q_data   <= '0;
    end else begin
      rd_ptr   <= rd_ptr_n;
      fifo_cnt <= cnt_after_pop + OW'(push);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      q_valid <= (cnt_after_pop != '0) || push;
      if (cnt_after_pop != '0) q_data <= mem[rd_ptr_n];
      else if (push)           q_data <= q_res;
    end
  end

endmodule

// File: tb/tb_inner_dot_t9_requant.sv
// Bench for inner_dot_t9_requant: behavioural MAC in front, scoreboard of
// requantized window results behind, directed then randomized windows.
module tb_inner_dot_t9_requant;

  localparam int SUM_WIDTH  = 20;
  localparam int TAPS       = 9;
  localparam int FIFO_DEPTH = 4;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        tap_valid;
  logic                        tap_ready;
  logic                        accum_clr;
  logic signed [SUM_WIDTH-1:0] sum;
  logic signed [15:0]          bias;
  logic        [3:0]           shift;
  logic                        relu_en;
  logic signed [7:0]           q_data;
  logic                        q_valid;
  logic                        q_ready;

  inner_dot_t9_requant #(
    .SUM_WIDTH(SUM_WIDTH), .TAPS(TAPS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tap_valid(tap_valid), .tap_ready(tap_ready),
    .accum_clr(accum_clr), .sum(sum), .bias(bias), .shift(shift),
    .relu_en(relu_en), .q_data(q_data), .q_valid(q_valid), .q_ready(q_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- external MAC model ----------------
  int t_d = 0;
  int t_w = 0;
  logic signed [31:0] acc = 0;
  always @(posedge clk) begin
    if (tap_valid && tap_ready) acc <= accum_clr ? t_d * t_w : acc + t_d * t_w;
  end
  assign sum = acc[SUM_WIDTH-1:0];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_q(input int s, input int b, input int sh, input bit relu);
    longint v;
    v = longint'(s) + longint'(b);
    if (sh != 0) v = (v + (64'sd1 <<< (sh - 1))) >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  logic signed [7:0] exp_q[$];
  int   n_pops    = 0;
  bit   hold_prev = 0;
  logic signed [7:0] prev_data = '0;

  // Scoreboard: sampled mid-cycle, after the stimulus has settled.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", q_valid, 1);
        check("hold_data", q_data, prev_data);
      end
      check("no_push_when_full",
            dut.push && (dut.fifo_cnt == FIFO_DEPTH) && !dut.pop, 0);
      if (q_valid && q_ready) begin
        n_pops++;
        if (exp_q.size() == 0) check("extra_output", q_valid, 0);
        else check("q_data", q_data, exp_q.pop_front());
      end
      hold_prev = q_valid && !q_ready;
      prev_data = q_data;
    end
  end

  // ---------------- driver tasks ----------------
  int win_d[TAPS];
  int win_w[TAPS];
  bit rand_rdy = 0;

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  task automatic send_tap(input int d, input int w);
    int  g  = 0;
    bit  ok = 0;
    tap_valid = 1'b1;
    t_d = d;
    t_w = w;
    while (!ok) begin
      if (rand_rdy) q_ready = 1'($urandom_range(0, 1));
      #1;
      ok = tap_ready;
      @(posedge clk);
      @(negedge clk);
      g++;
      if (g > 500) begin
        check("tap_accept_timeout", tap_ready, 1);
        finish_run();
      end
    end
  endtask

  task automatic fill(input int d0, input int w0, input int dr, input int wr);
    for (int i = 0; i < TAPS; i++) begin
      win_d[i] = (i == 0) ? d0 : dr;
      win_w[i] = (i == 0) ? w0 : wr;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < TAPS; i++) begin
      win_d[i] = int'($urandom_range(0, 255)) - 128;
      win_w[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Window parameters change only after the previous window has sampled them.
  task automatic send_window(input int b, input int sh, input bit relu);
    int s = 0;
    for (int i = 0; i < TAPS; i++) begin
      s += win_d[i] * win_w[i];
      send_tap(win_d[i], win_w[i]);
      if (i == 0) begin
        bias    = 16'(b);
        shift   = 4'(sh);
        relu_en = relu;
      end
    end
    exp_q.push_back(8'(ref_q(s, b, sh, relu)));
  endtask

  task automatic idle(input int n);
    tap_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    tap_valid = 1'b0;
    q_ready   = 1'b1;
    while (exp_q.size() != 0 || q_valid) begin
      @(negedge clk);
      g++;
      if (g > 200) begin
        check("drain_timeout", exp_q.size(), 0);
        finish_run();
      end
    end
    idle(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int p0;
    rst_n = 1'b0; tap_valid = 1'b0; q_ready = 1'b1;
    bias = '0; shift = '0; relu_en = 1'b0;
    #1;
    check("rst_q_valid", q_valid, 0);
    check("rst_q_data", q_data, 0);
    check("rst_tap_ready", tap_ready, 1);
    check("rst_accum_clr", accum_clr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Basic window with latency probe.
    tap_valid = 1'b1; t_d = 10; t_w = 10;
    #1;
    check("first_tap_clr", accum_clr, 1);
    fill(10, 10, 10, 10);
    send_window(0, 4, 0);
    tap_valid = 1'b0;
    #1;
    check("lat_c1_valid", q_valid, 0);
    @(negedge clk); #1;
    check("lat_c2_valid", q_valid, 0);
    @(negedge clk); #1;
    check("lat_c3_valid", q_valid, 1);
    check("basic_q_data", q_data, 56);
    drain();

    // Saturation, ReLU and rounding windows.
    fill(127, 127, 127, 127);   send_window(0, 8, 0);
    fill(-128, 127, -128, 127); send_window(0, 8, 0);
    fill(-128, 127, -128, 127); send_window(0, 8, 1);
    fill(24, 1, 0, 0);          send_window(0, 4, 0);
    fill(-24, 1, 0, 0);         send_window(0, 4, 0);
    fill(10, 10, 10, 10);       send_window(-900, 0, 0);
    drain();

    // Back-to-back throughput: three windows in exactly three window periods.
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      fill_rand();
      send_window(int'($urandom_range(0, 2000)) - 1000, 6, 0);
    end
    check("no_bubble_cycles", cyc - c0, 3 * TAPS);
    drain();

    // Backpressure: four windows fill the budget, the fifth start is held.
    q_ready = 1'b0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      fill_rand();
      send_window(int'($urandom_range(0, 600)) - 300, 5, 0);
    end
    tap_valid = 1'b1; t_d = 1; t_w = 1;
    #1;
    check("bp_tap_ready", tap_ready, 0);
    check("bp_accum_clr", accum_clr, 0);
    repeat (3) @(negedge clk);
    #1;
    check("bp_still_held", tap_ready, 0);
    check("bp_q_valid", q_valid, 1);
    @(negedge clk);
    q_ready = 1'b1;
    @(negedge clk);
    q_ready = 1'b0;
    #1;
    check("bp_ready_restored", tap_ready, 1);
    fill_rand();
    send_window(77, 3, 0);
    drain();

    // Reset with two results buffered and a window half done.
    q_ready = 1'b0;
    fill(10, 10, 10, 10);
    send_window(0, 4, 0);
    send_window(0, 4, 0);
    idle(4);
    for (int i = 0; i < 5; i++) send_tap(3, 3);
    tap_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_q_valid", q_valid, 0);
    check("mid_rst_q_data", q_data, 0);
    check("mid_rst_tap_ready", tap_ready, 1);
    check("mid_rst_accum_clr", accum_clr, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q_ready = 1'b1;
    tap_valid = 1'b1; t_d = 10; t_w = 10;
    #1;
    check("post_rst_clr", accum_clr, 1);
    p0 = n_pops;
    send_window(0, 4, 0);
    drain();
    idle(4);
    check("post_rst_single_result", n_pops - p0, 1);

    // Randomized windows with random consumer stalls.
    rand_rdy = 1;
    for (int k = 0; k < 25; k++) begin
      fill_rand();
      send_window(int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    rand_rdy = 0;
    drain();

    finish_run();
  end

endmodule

// File: doc/inner_dot_t9_requant.md
INNER_DOT_T9_REQUANT -- requirements
Module: inner_dot_t9_requant

Interface
REQ-001 SHALL have parameter SUM_WIDTH, default 20: width of the accumulated MAC sum.
REQ-002 SHALL have parameter TAPS, default 9: products per window (3x3 kernel).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries, and also the limit on outstanding windows.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 tap_valid  in  1  a data/weight pair is presented to the MAC this cycle.
REQ-007 tap_ready  out  1  the tap is accepted; a tap is taken on an edge only when tap_valid&&tap_ready.
REQ-008 accum_clr  out  1  drives the MAC clear/load input.
REQ-009 sum  in  SUM_WIDTH signed  MAC accumulator output.
REQ-010 bias  in  16 signed  per-window bias.
REQ-011 shift  in  4 unsigned  requantization right-shift, 0..15.
REQ-012 relu_en  in  1  clamp negative results to 0.
REQ-013 q_data  out  8 signed  quantized result at the FIFO head.
REQ-014 q_valid  out  1  q_data is valid.
REQ-015 q_ready  in  1  consumer accepts; pop on q_valid&&q_ready.

Function
REQ-016 SHALL keep tap counter cnt, 0..TAPS-1, that advances on each accepted tap and wraps TAPS-1 -> 0.
REQ-017 SHALL drive accum_clr = tap_valid && tap_ready && cnt==0, combinationally.
REQ-018 SHALL keep counter outst, 0..FIFO_DEPTH, of windows started but not popped.
REQ-019 outst SHALL increment on an accepted tap with cnt==0 and decrement on a pop; simultaneous increment and decrement SHALL leave it unchanged.
REQ-020 tap_ready SHALL be 1 when cnt!=0; when cnt==0 it SHALL be 1 only if outst<FIFO_DEPTH.
REQ-021 Accepting a tap with cnt==TAPS-1 SHALL set register done_d for one cycle.
REQ-022 On the edge after done_d=1, SHALL register s1 = sum + sign-extended bias, at SUM_WIDTH+1 bits, and set s1_v.
- bias, shift and relu_en SHALL be sampled on this same edge.
REQ-023 Stage 2 SHALL compute r as follows.
- shift==0: r = s1.
- Otherwise: r = (s1 + 2^(shift-1)) >>> shift, arithmetic, round-half-up, with no intermediate overflow.
REQ-024 Stage 2 SHALL then apply ReLU: if relu_en and r<0, then r=0.
REQ-025 Stage 2 SHALL then saturate r to [-128,127].
REQ-026 Stage 2 SHALL push the result into the FIFO on the edge after s1_v=1.
REQ-027 Latency: q_valid SHALL rise 3 cycles after the edge that accepts the last tap, when the FIFO is empty.
REQ-028 Back-to-back windows SHALL run with no bubble.
- The sum is captured on the same edge the next window's accum_clr loads the MAC.
- One window per TAPS cycles SHALL be sustained when q_ready=1.
REQ-029 FIFO SHALL be first-word-fall-through; q_data/q_valid SHALL come from registers.
- A simultaneous push and pop SHALL be legal at any occupancy, including full.
REQ-030 outst gating SHALL guarantee the FIFO never overflows.
- A push while full SHALL be impossible; a bench assertion SHALL check this.
REQ-031 q_data SHALL hold stable while q_valid && !q_ready.
REQ-032 A pop with the FIFO empty SHALL have no effect.

Reset
REQ-033 rst_n low SHALL asynchronously clear all of the following to 0: cnt, outst, done_d, s1, s1_v, FIFO pointers and occupancy, q_valid, q_data.
REQ-034 During reset: tap_ready=1, accum_clr=0 whenever tap_valid=0, q_valid=0.
REQ-035 Reset in mid-window or with the FIFO partly full SHALL discard all partial and buffered results.
- The first tap after release SHALL be treated as cnt==0 and SHALL assert accum_clr.

Verification
REQ-036 Basic: 9 taps of data=10, weight=10; bias=0, shift=4, relu_en=0.
- Sum is 900; (900+8)>>4 = 56.
- Response: q_data=56, q_valid=1, 3 cycles after the 9th tap.
REQ-037 Saturation: 9 taps of 127*127, sum 145161, shift=8.
- Response: q_data=127.
- Then 9 taps of -128*127, sum -146304, shift=8: q_data=-128.
- Same negative window with relu_en=1: q_data=0.
REQ-038 Rounding: sum=24, shift=4 -> q_data=2. Sum=-24, shift=4 -> q_data=-1. Sum=900, bias=-900, shift=0 -> q_data=0.
REQ-039 Backpressure: q_ready=0, 5 windows offered back-to-back.
- Four windows are accepted; tap_ready is 0 at cnt==0 of the 5th.
- One pop restores tap_ready on the next cycle.
- Outputs emerge in order; no overflow.
REQ-040 Reset mid-operation: assert rst_n=0 after 5 taps, with 2 results buffered.
- Response: q_valid=0 and outputs at 0 immediately.
- After release, 9 taps of 10*10 with shift=4 produce a single q_data=56.
